// File: rtl/rtc_display_scheduler.sv
// rtl/rtc_display_scheduler.sv - periodic RTC register sweep with atomic display commit and write arbitration
//
// Sweeps ten RTC registers over the shared bus-cycle engine, collects them in a
// shadow file and copies them to the display digits in a single cycle, so the
// screen never shows a partially updated time. Configuration writes share the
// bus and take priority at every arbitration point; a write that lands during a
// sweep restarts that sweep.
//
// Ports:
//   clock, reset (async, active-low)
//   refresh_en, formato_hora             - sweep enable, 12 h (1) / 24 h (0) decode
//   wr_req, wr_addr, wr_data, wr_done    - configuration write handshake
//   bus_req, bus_we, bus_addr, bus_wdata - request to the bus-cycle engine
//   bus_ack, bus_rdata                   - completion and read data from the engine
//   digit0_*/digit1_*                    - committed BCD units/tens digits
//   AM_PM, timer_end, frame_valid        - committed flags and commit pulse
//   busy, bus_err                        - not-idle level, timeout pulse
module rtc_display_scheduler #(
    parameter int REFRESH_CYCLES = 10_000_000,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       refresh_en,
    input  logic       formato_hora,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_done,
    output logic       bus_req,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic       bus_ack,
    input  logic [7:0] bus_rdata,
    output logic [3:0] digit0_SS,
    output logic [3:0] digit1_SS,
    output logic [3:0] digit0_MM,
    output logic [3:0] digit1_MM,
    output logic [3:0] digit0_HH,
    output logic [3:0] digit1_HH,
    output logic [3:0] digit0_DAY,
    output logic [3:0] digit1_DAY,
    output logic [3:0] digit0_MON,
    output logic [3:0] digit1_MON,
    output logic [3:0] digit0_YEAR,
    output logic [3:0] digit1_YEAR,
    output logic [3:0] digit0_SS_T,
    output logic [3:0] digit1_SS_T,
    output logic [3:0] digit0_MM_T,
    output logic [3:0] digit1_MM_T,
    output logic [3:0] digit0_HH_T,
    output logic [3:0] digit1_HH_T,
    output logic       AM_PM,
    output logic       timer_end,
    output logic       frame_valid,
    output logic       busy,
    output logic       bus_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARB    = 3'd1;
    localparam logic [2:0] S_RD_REQ = 3'd2;
    localparam logic [2:0] S_WR_REQ = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state;
    logic [3:0]    idx;
    logic [CW-1:0] ref_cnt;
    logic [TW-1:0] to_cnt;
    logic          sweep_pend;
    logic          sweep_act;
    logic [7:0]    shadow [10];

    // Top bits of the BCD registers and the unused status bits never reach a display.
    logic unused_shadow_bits;
    assign unused_shadow_bits = ^{shadow[0][7], shadow[1][7], shadow[2][7:6], shadow[3][7],
                                  shadow[4][7], shadow[5][7], shadow[6][7], shadow[7][7],
                                  shadow[8][7:6], shadow[9][7:1]};

    function automatic logic [7:0] sweep_addr(input logic [3:0] i);
        case (i)
            4'd0:    sweep_addr = 8'h21;
            4'd1:    sweep_addr = 8'h22;
            4'd2:    sweep_addr = 8'h23;
            4'd3:    sweep_addr = 8'h24;
            4'd4:    sweep_addr = 8'h25;
            4'd5:    sweep_addr = 8'h26;
            4'd6:    sweep_addr = 8'h41;
            4'd7:    sweep_addr = 8'h42;
            4'd8:    sweep_addr = 8'h43;
            default: sweep_addr = 8'h0F;
        endcase
    endfunction

    // wr_req is still high in the wr_done cycle; ignore it there so one
    // request cannot launch a second write.
    logic wr_take;
    assign wr_take = wr_req && !wr_done;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            ref_cnt     <= '0;
            to_cnt      <= '0;
            sweep_pend  <= 1'b1;
            sweep_act   <= 1'b0;
            for (int i = 0; i < 10; i++) shadow[i] <= '0;
            wr_done     <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            frame_valid <= 1'b0;
            bus_err     <= 1'b0;
            digit0_SS   <= '0;  digit1_SS   <= '0;
            digit0_MM   <= '0;  digit1_MM   <= '0;
            digit0_HH   <= '0;  digit1_HH   <= '0;
            digit0_DAY  <= '0;  digit1_DAY  <= '0;
            digit0_MON  <= '0;  digit1_MON  <= '0;
            digit0_YEAR <= '0;  digit1_YEAR <= '0;
            digit0_SS_T <= '0;  digit1_SS_T <= '0;
            digit0_MM_T <= '0;  digit1_MM_T <= '0;
            digit0_HH_T <= '0;  digit1_HH_T <= '0;
            AM_PM       <= 1'b0;
            timer_end   <= 1'b0;
        end else begin
            wr_done     <= 1'b0;
            frame_valid <= 1'b0;
            bus_err     <= 1'b0;

            // Free-running period counter; a wrap during a running sweep is dropped.
            if (ref_cnt == REF_LAST) begin
                ref_cnt <= '0;
                if (!sweep_act) sweep_pend <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (wr_take) begin
                        state     <= S_WR_REQ;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_addr  <= wr_addr;
                        bus_wdata <= wr_data;
                        to_cnt    <= '0;
                    end else if (sweep_pend && refresh_en) begin
                        state      <= S_ARB;
                        idx        <= '0;
                        sweep_pend <= 1'b0;
                        sweep_act  <= 1'b1;
                    end
                end
                S_ARB: begin
                    to_cnt  <= '0;
                    bus_req <= 1'b1;
                    if (wr_take) begin
                        state     <= S_WR_REQ;
                        bus_we    <= 1'b1;
                        bus_addr  <= wr_addr;
                        bus_wdata <= wr_data;
                    end else begin
                        state    <= S_RD_REQ;
                        bus_we   <= 1'b0;
                        bus_addr <= sweep_addr(idx);
                    end
                end
                S_RD_REQ, S_WR_REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        if (state == S_RD_REQ) begin
                            shadow[idx] <= bus_rdata;
                            if (idx == 4'd9) begin
                                state <= S_COMMIT;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= S_ARB;
                            end
                        end else begin
                            wr_done <= 1'b1;
                            // Registers already read may be stale now, so re-read all.
                            if (sweep_act) begin
                                idx   <= '0;
                                state <= S_ARB;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end else if (to_cnt == TO_LAST) begin
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_err   <= 1'b1;
                        wr_done   <= (state == S_WR_REQ);
                        sweep_act <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_COMMIT: begin
                    digit0_SS   <= shadow[0][3:0];  digit1_SS   <= {1'b0, shadow[0][6:4]};
                    digit0_MM   <= shadow[1][3:0];  digit1_MM   <= {1'b0, shadow[1][6:4]};
                    digit0_HH   <= shadow[2][3:0];
                    digit1_HH   <= formato_hora ? {3'b0, shadow[2][4]} : {2'b0, shadow[2][5:4]};
                    digit0_DAY  <= shadow[3][3:0];  digit1_DAY  <= {1'b0, shadow[3][6:4]};
                    digit0_MON  <= shadow[4][3:0];  digit1_MON  <= {1'b0, shadow[4][6:4]};
                    digit0_YEAR <= shadow[5][3:0];  digit1_YEAR <= {1'b0, shadow[5][6:4]};
                    digit0_SS_T <= shadow[6][3:0];  digit1_SS_T <= {1'b0, shadow[6][6:4]};
                    digit0_MM_T <= shadow[7][3:0];  digit1_MM_T <= {1'b0, shadow[7][6:4]};
                    digit0_HH_T <= shadow[8][3:0];
                    digit1_HH_T <= formato_hora ? {3'b0, shadow[8][4]} : {2'b0, shadow[8][5:4]};
                    AM_PM       <= formato_hora & shadow[2][5];
                    timer_end   <= shadow[9][0];
                    frame_valid <= 1'b1;
                    sweep_act   <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_display_scheduler.sv
// tb/tb_rtc_display_scheduler.sv - directed self-checking bench for rtc_display_scheduler
module tb_rtc_display_scheduler;

    logic       clock;
    logic       reset;
    logic       refresh_en;
    logic       formato_hora;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_done;
    logic       bus_req;
    logic       bus_we;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_ack;
    logic [7:0] bus_rdata;
    logic [3:0] digit0_SS, digit1_SS, digit0_MM, digit1_MM, digit0_HH, digit1_HH;
    logic [3:0] digit0_DAY, digit1_DAY, digit0_MON, digit1_MON, digit0_YEAR, digit1_YEAR;
    logic [3:0] digit0_SS_T, digit1_SS_T, digit0_MM_T, digit1_MM_T, digit0_HH_T, digit1_HH_T;
    logic       AM_PM;
    logic       timer_end;
    logic       frame_valid;
    logic       busy;
    logic       bus_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];
    logic       no_ack_en;
    logic [7:0] no_ack_addr;

    // Bus engine model: acks in the first request cycle unless told to stall one address.
    assign bus_ack   = bus_req && !(no_ack_en && bus_addr == no_ack_addr);
    assign bus_rdata = bus_ack ? mem[bus_addr] : 8'h00;

    rtc_display_scheduler #(.REFRESH_CYCLES(100), .TIMEOUT_CYCLES(255)) dut (
        .clock(clock), .reset(reset), .refresh_en(refresh_en), .formato_hora(formato_hora),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .digit0_SS(digit0_SS), .digit1_SS(digit1_SS), .digit0_MM(digit0_MM), .digit1_MM(digit1_MM),
        .digit0_HH(digit0_HH), .digit1_HH(digit1_HH), .digit0_DAY(digit0_DAY), .digit1_DAY(digit1_DAY),
        .digit0_MON(digit0_MON), .digit1_MON(digit1_MON), .digit0_YEAR(digit0_YEAR),
        .digit1_YEAR(digit1_YEAR), .digit0_SS_T(digit0_SS_T), .digit1_SS_T(digit1_SS_T),
        .digit0_MM_T(digit0_MM_T), .digit1_MM_T(digit1_MM_T), .digit0_HH_T(digit0_HH_T),
        .digit1_HH_T(digit1_HH_T), .AM_PM(AM_PM), .timer_end(timer_end),
        .frame_valid(frame_valid), .busy(busy), .bus_err(bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frame(input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clock);
            if (frame_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_addr(input logic [7:0] a, input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clock);
            if (bus_req && bus_addr == a) ok = 1'b1;
        end
    endtask

    logic ok;
    int   fv_count, fv_first, n, bad;
    logic [7:0] first_addr;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h21] = 8'h59; mem[8'h22] = 8'h34; mem[8'h23] = 8'h12; mem[8'h24] = 8'h28;
        mem[8'h25] = 8'h07; mem[8'h26] = 8'h24; mem[8'h41] = 8'h30; mem[8'h42] = 8'h05;
        mem[8'h43] = 8'h01; mem[8'h0F] = 8'h01;
        no_ack_en = 1'b0; no_ack_addr = 8'h00;
        reset = 1'b0; refresh_en = 1'b1; formato_hora = 1'b0;
        wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_digit1_SS", digit1_SS, 0);
        chk("rst_frame_valid", frame_valid, 0);

        // First sweep: one commit, 22 edges after release
        reset = 1'b1;
        fv_count = 0; fv_first = 0; first_addr = 8'h00;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (k == 2) first_addr = bus_addr;
            if (frame_valid) begin
                fv_count++;
                if (fv_first == 0) fv_first = k;
            end
        end
        chk("first_read_addr", first_addr, 8'h21);
        chk("first_fv_cycle", fv_first, 22);
        chk("first_fv_count", fv_count, 1);
        chk("ss_tens", digit1_SS, 5);   chk("ss_units", digit0_SS, 9);
        chk("mm_tens", digit1_MM, 3);   chk("mm_units", digit0_MM, 4);
        chk("hh_tens", digit1_HH, 1);   chk("hh_units", digit0_HH, 2);
        chk("day", {digit1_DAY, digit0_DAY}, 8'h28);
        chk("year", {digit1_YEAR, digit0_YEAR}, 8'h24);
        chk("timer_end", timer_end, 1);
        chk("am_pm_24h", AM_PM, 0);

        // 12 h decode
        formato_hora = 1'b1; mem[8'h23] = 8'h31; mem[8'h43] = 8'h32;
        wait_frame(200, ok);
        chk("f12_seen", ok, 1);
        chk("f12_hh_tens", digit1_HH, 1); chk("f12_hh_units", digit0_HH, 1);
        chk("f12_am_pm", AM_PM, 1);
        chk("f12_hht_tens", digit1_HH_T, 1); chk("f12_hht_units", digit0_HH_T, 2);

        // 24 h decode
        formato_hora = 1'b0; mem[8'h23] = 8'h23;
        wait_frame(200, ok);
        chk("f24_seen", ok, 1);
        chk("f24_hh_tens", digit1_HH, 2); chk("f24_hh_units", digit0_HH, 3);
        chk("f24_am_pm", AM_PM, 0);
        chk("f24_hht_tens", digit1_HH_T, 3);

        // Atomicity: seconds change before it is read, minutes after
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (busy) ok = 1'b1;
        end
        chk("atom_start", ok, 1);
        mem[8'h21] = 8'h00;
        bad = 0; ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clock);
            if (bus_req && bus_addr == 8'h24) mem[8'h22] = 8'h35;
            if (frame_valid) ok = 1'b1;
            else if ({digit1_SS, digit0_SS} != 8'h59) bad++;
        end
        chk("atom_seen", ok, 1);
        chk("atom_no_tear", bad, 0);
        chk("atom_ss", {digit1_SS, digit0_SS}, 8'h00);
        chk("atom_mm", {digit1_MM, digit0_MM}, 8'h34);

        // Write arbitration during read index 4
        wait_addr(8'h25, 200, ok);
        chk("wr_idx4_seen", ok, 1);
        wr_req = 1'b1; wr_addr = 8'h22; wr_data = 8'h45;
        @(negedge clock);
        chk("wr_gap", bus_req, 0);
        @(negedge clock);
        chk("wr_issue", {bus_req, bus_we, bus_addr, bus_wdata}, {2'b11, 8'h22, 8'h45});
        if (bus_req && bus_we) mem[bus_addr] = bus_wdata;
        @(negedge clock);
        chk("wr_done", wr_done, 1);
        wr_req = 1'b0;
        @(negedge clock);
        chk("wr_restart", {bus_req, bus_we, bus_addr}, {2'b10, 8'h21});
        wait_frame(60, ok);
        chk("wr_frame_seen", ok, 1);
        chk("wr_mm", {digit1_MM, digit0_MM}, 8'h45);

        // Timeout on day register
        no_ack_en = 1'b1; no_ack_addr = 8'h24;
        wait_addr(8'h24, 200, ok);
        chk("to_seen", ok, 1);
        n = 1; bad = 0; ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clock);
            if (frame_valid) bad++;
            if (bus_req) n++;
            else ok = 1'b1;
        end
        chk("to_req_cycles", n, 255);
        chk("to_bus_err", bus_err, 1);
        chk("to_no_frame", bad, 0);
        chk("to_idle", busy, 0);
        chk("to_hold", {digit1_SS, digit0_SS, digit1_MM, digit0_MM}, 16'h0045);
        no_ack_en = 1'b0;
        wait_frame(250, ok);
        chk("to_recover", ok, 1);

        // refresh_en low: no new sweep
        refresh_en = 1'b0;
        bad = 0;
        repeat (250) begin
            @(negedge clock);
            if (busy) bad++;
        end
        chk("ren_low_idle", bad, 0);
        refresh_en = 1'b1;
        wait_frame(250, ok);
        chk("ren_high_frame", ok, 1);

        // Reset mid-transaction
        wait_addr(8'h23, 200, ok);
        chk("rmid_seen", ok, 1);
        #2 reset = 1'b0;
        #1;
        chk("rmid_bus_req", bus_req, 0);
        chk("rmid_digits", {digit1_MM, digit0_MM, digit1_HH, digit0_HH}, 16'h0000);
        chk("rmid_timer_end", timer_end, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rmid_arb", {busy, bus_req}, 2'b10);
        @(negedge clock);
        chk("rmid_first_read", {bus_req, bus_addr}, {1'b1, 8'h21});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
